// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared AHB master-side types and defaults.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ahb_master_req_ctrl_pkg;

    // Request controller state: waiting for a command, requesting beat 0, streaming the rest.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } req_state_e;

    // Priority width shared with the arbiter generator; both ends must agree.
    localparam int AHB_PRIOR_BIT = 1;

    // Counter width able to hold 0 .. term (at least one bit).
    function automatic int cnt_width(input int term);
        return (term > 0) ? $clog2(term + 1) : 1;
    endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_timeout_cnt.sv
// Saturating cycle counter with clear/enable and a terminal-count flag.
// Latency: tc_o is registered state, valid the cycle the count reaches TERM.
// Backpressure: none; clear has priority over enable, count holds at TERM.
module ahb_master_req_ctrl_timeout_cnt #(
    parameter int CNT_W = 8,
    parameter int TERM  = 254
) (
    input  logic hclk,
    input  logic hreset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TERM))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Master-side burst request controller driving one-hot hreq/hlast to the slave arbiters.
// Latency: hreq one cycle after command accept; done/timeout pulse the cycle after the final beat/abort.
// Backpressure: cmd_ready only in IDLE; beats stall while the selected hgrant is low, aborting after TIMEOUT idle cycles.
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int SLAVE_NUM = 4,
    parameter int SLAVE_BIT = $clog2(SLAVE_NUM),
    parameter int PRIOR_BIT = AHB_PRIOR_BIT,
    parameter int BEAT_W    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [SLAVE_BIT-1:0] cmd_slave,
    input  logic [BEAT_W-1:0]    cmd_len,
    input  logic [PRIOR_BIT-1:0] cmd_prior,
    output logic [SLAVE_NUM-1:0] hreq,
    output logic [SLAVE_NUM-1:0] hlast,
    output logic [PRIOR_BIT-1:0] hprior,
    input  logic [SLAVE_NUM-1:0] hgrant,
    output logic                 beat_en,
    output logic [BEAT_W-1:0]    beat_cnt,
    output logic                 done,
    output logic                 timeout
);

    localparam int TMO_TERM = TIMEOUT - 1;
    localparam int TMO_W    = cnt_width(TMO_TERM);

    req_state_e           state_q, state_d;
    logic [SLAVE_BIT-1:0] slave_q, slave_d;
    logic [BEAT_W-1:0]    len_q, len_d;
    logic [PRIOR_BIT-1:0] prior_q, prior_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;

    logic                 busy;
    logic                 grant_sel;
    logic                 last_beat;
    logic                 tmo_clr;
    logic                 tmo_en;
    logic                 tmo_tc;
    logic [SLAVE_NUM-1:0] slave_oh;

    assign busy      = (state_q != ST_IDLE);
    // Only the addressed arbiter's grant matters; the rest are ignored.
    assign grant_sel = busy && hgrant[slave_q];
    // In REQ the beat index is still 0, so last is simply a zero-length burst.
    assign last_beat = ((state_q == ST_REQ)  && (len_q == '0)) ||
                       ((state_q == ST_XFER) && (beat_cnt_q == len_q));

    // Stall counter runs only while requesting and is reset by any accepted beat.
    assign tmo_clr = !busy || grant_sel;
    assign tmo_en  = busy && !grant_sel;

    ahb_master_req_ctrl_timeout_cnt #(
        .CNT_W (TMO_W),
        .TERM  (TMO_TERM)
    ) u_timeout_cnt (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .tc_o     (tmo_tc)
    );

    // Next-state and burst bookkeeping; a grant in the terminal stall cycle beats the abort.
    always_comb begin
        state_d    = state_q;
        slave_d    = slave_q;
        len_d      = len_q;
        prior_d    = prior_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    slave_d    = cmd_slave;
                    len_d      = cmd_len;
                    prior_d    = cmd_prior;
                    beat_cnt_d = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant_sel) begin
                    if (len_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        state_d    = ST_XFER;
                    end
                end else if (tmo_tc) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (grant_sel) begin
                    if (beat_cnt_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end else if (tmo_tc) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command registers.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= ST_IDLE;
            slave_q    <= '0;
            len_q      <= '0;
            prior_q    <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slave_q    <= slave_d;
            len_q      <= len_d;
            prior_q    <= prior_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Slave index decoder used to steer hreq/hlast.
    always_comb begin
        slave_oh          = '0;
        slave_oh[slave_q] = 1'b1;
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign hreq      = busy      ? slave_oh : '0;
    assign hlast     = last_beat ? slave_oh : '0;
    assign hprior    = busy      ? prior_q  : '0;
    assign beat_en   = grant_sel;
    assign beat_cnt  = beat_cnt_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed bench for ahb_master_req_ctrl with TIMEOUT=8.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: grants are driven per cycle from hand-written patterns.
module tb_ahb_master_req_ctrl;

    logic       hclk;
    logic       hreset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_slave;
    logic [3:0] cmd_len;
    logic [0:0] cmd_prior;
    logic [3:0] hreq;
    logic [3:0] hlast;
    logic [0:0] hprior;
    logic [3:0] hgrant;
    logic       beat_en;
    logic [3:0] beat_cnt;
    logic       done;
    logic       timeout;

    int n_total;
    int n_bad;

    int g4[6]   = '{1, 0, 1, 1, 0, 1};
    int cnt4[6] = '{0, 1, 1, 2, 3, 3};

    ahb_master_req_ctrl #(
        .SLAVE_NUM (4),
        .SLAVE_BIT (2),
        .PRIOR_BIT (1),
        .BEAT_W    (4),
        .TIMEOUT   (8)
    ) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_slave (cmd_slave),
        .cmd_len   (cmd_len),
        .cmd_prior (cmd_prior),
        .hreq      (hreq),
        .hlast     (hlast),
        .hprior    (hprior),
        .hgrant    (hgrant),
        .beat_en   (beat_en),
        .beat_cnt  (beat_cnt),
        .done      (done),
        .timeout   (timeout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        hreset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_slave = 2'd0;
        cmd_len   = 4'd0;
        cmd_prior = 1'b0;
        hgrant    = 4'b0000;
        #12;
        chk("rst_ready",    32'(cmd_ready), 1);
        chk("rst_hreq",     32'(hreq), 0);
        chk("rst_hlast",    32'(hlast), 0);
        chk("rst_hprior",   32'(hprior), 0);
        chk("rst_beat_cnt", 32'(beat_cnt), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_timeout",  32'(timeout), 0);
        tick();
        hreset_n = 1'b1;
        tick();

        // single beat to slave 2, grant two cycles after hreq
        cmd_valid = 1'b1; cmd_slave = 2'd2; cmd_len = 4'd0; cmd_prior = 1'b1;
        #1;
        chk("sb_ready_idle", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("sb_hreq",   32'(hreq), 32'h4);
        chk("sb_hlast",  32'(hlast), 32'h4);
        chk("sb_hprior", 32'(hprior), 1);
        chk("sb_ready_busy", 32'(cmd_ready), 0);
        tick(); #1;
        chk("sb_no_beat", 32'(beat_en), 0);
        tick();
        hgrant = 4'b0100;
        #1;
        chk("sb_beat_en", 32'(beat_en), 1);
        tick();
        hgrant = 4'b0000;
        #1;
        chk("sb_done",    32'(done), 1);
        chk("sb_hreq_off", 32'(hreq), 0);
        chk("sb_hlast_off", 32'(hlast), 0);
        chk("sb_hprior_off", 32'(hprior), 0);
        tick(); #1;
        chk("sb_done_pulse", 32'(done), 0);

        // four-beat burst to slave 1 with stalls
        cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_len = 4'd3; cmd_prior = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hgrant = (g4[i] != 0) ? 4'b0010 : 4'b0000;
            #1;
            chk("b4_cnt",   32'(beat_cnt), 32'(cnt4[i]));
            chk("b4_hlast", 32'(hlast), (cnt4[i] == 3) ? 32'h2 : 32'h0);
            chk("b4_hreq",  32'(hreq), 32'h2);
            chk("b4_beat",  32'(beat_en), 32'(g4[i]));
            chk("b4_no_done", 32'(done), 0);
            tick();
        end
        hgrant = 4'b0000;
        #1;
        chk("b4_done", 32'(done), 1);
        chk("b4_hreq_off", 32'(hreq), 0);
        tick(); #1;
        chk("b4_done_once", 32'(done), 0);

        // timeout with no grants at all
        cmd_valid = 1'b1; cmd_slave = 2'd3; cmd_len = 4'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_hreq", 32'(hreq), 32'h8);
            chk("to_early", 32'(timeout), 0);
            tick();
        end
        #1;
        chk("to_pulse",   32'(timeout), 1);
        chk("to_hreq_off", 32'(hreq), 0);
        chk("to_no_done", 32'(done), 0);
        chk("to_ready",   32'(cmd_ready), 1);
        tick(); #1;
        chk("to_pulse_end", 32'(timeout), 0);

        // grant arriving in the terminal stall cycle wins over the abort
        cmd_valid = 1'b1; cmd_slave = 2'd0; cmd_len = 4'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("gt_hreq", 32'(hreq), 32'h1);
            tick();
        end
        hgrant = 4'b0001;
        #1;
        chk("gt_beat", 32'(beat_en), 1);
        tick();
        hgrant = 4'b0000;
        #1;
        chk("gt_done", 32'(done), 1);
        chk("gt_no_timeout", 32'(timeout), 0);
        tick();

        // grants for another slave are ignored
        cmd_valid = 1'b1; cmd_slave = 2'd0; cmd_len = 4'd1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hgrant = 4'b0010;
            #1;
            chk("ws_beat", 32'(beat_en), 0);
            chk("ws_cnt",  32'(beat_cnt), 0);
            tick();
        end
        hgrant = 4'b0001;
        #1;
        chk("ws_beat0", 32'(beat_en), 1);
        chk("ws_hlast0", 32'(hlast), 0);
        tick(); #1;
        chk("ws_cnt1",  32'(beat_cnt), 1);
        chk("ws_hlast1", 32'(hlast), 32'h1);
        tick();
        hgrant = 4'b0000;
        #1;
        chk("ws_done", 32'(done), 1);
        tick();

        // back-to-back: second command held while busy, taken in the done cycle
        cmd_valid = 1'b1; cmd_slave = 2'd2; cmd_len = 4'd1;
        tick();
        cmd_slave = 2'd3; cmd_len = 4'd0;
        hgrant = 4'b0100;
        #1;
        chk("bb_ready_busy", 32'(cmd_ready), 0);
        tick(); #1;
        chk("bb_hreq_first", 32'(hreq), 32'h4);
        chk("bb_cnt1", 32'(beat_cnt), 1);
        tick();
        hgrant = 4'b0000;
        #1;
        chk("bb_done1", 32'(done), 1);
        chk("bb_gap",   32'(hreq), 0);
        chk("bb_ready_done", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("bb_hreq_second", 32'(hreq), 32'h8);
        chk("bb_done_low", 32'(done), 0);
        hgrant = 4'b1000;
        #1;
        chk("bb_beat2", 32'(beat_en), 1);
        tick();
        hgrant = 4'b0000;
        #1;
        chk("bb_done2", 32'(done), 1);
        tick();

        // full 16-beat burst: no wrap, hlast only on beat 15
        cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_len = 4'd15;
        tick();
        cmd_valid = 1'b0;
        hgrant = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("b16_cnt",   32'(beat_cnt), 32'(i));
            chk("b16_hlast", 32'(hlast), (i == 15) ? 32'h2 : 32'h0);
            tick();
        end
        hgrant = 4'b0000;
        #1;
        chk("b16_done", 32'(done), 1);
        chk("b16_hreq_off", 32'(hreq), 0);
        tick();

        // reset asserted at beat 2 of an 8-beat burst
        cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_len = 4'd7;
        tick();
        cmd_valid = 1'b0;
        hgrant = 4'b0010;
        tick();
        tick();
        #1;
        chk("rm_cnt2", 32'(beat_cnt), 2);
        chk("rm_hreq", 32'(hreq), 32'h2);
        hreset_n = 1'b0;
        #1;
        chk("rm_hreq_async",  32'(hreq), 0);
        chk("rm_hlast_async", 32'(hlast), 0);
        chk("rm_cnt_async",   32'(beat_cnt), 0);
        hgrant = 4'b0000;
        tick();
        tick();
        hreset_n = 1'b1;
        #1;
        chk("rm_ready", 32'(cmd_ready), 1);
        tick(); #1;
        chk("rm_no_done",    32'(done), 0);
        chk("rm_no_timeout", 32'(timeout), 0);
        chk("rm_idle_hreq",  32'(hreq), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
